// File: rtl/debug_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single read/write slave port.
// One transaction outstanding at a time; slave-side request, address and data are registered.
module debug_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    m_wreq,
  output logic [1:0]    m_wgnt,
  input  logic [2*AW-1:0] m_waddr,
  input  logic [2*DW-1:0] m_wdata,
  input  logic [1:0]    m_rreq,
  output logic [1:0]    m_rgnt,
  input  logic [2*AW-1:0] m_raddr,
  output logic [DW-1:0] m_rdata,
  output logic          s_wreq,
  output logic          s_rreq,
  input  logic          s_wgnt,
  input  logic          s_rgnt,
  output logic [AW-1:0] s_waddr,
  output logic [AW-1:0] s_raddr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  output logic          owner,
  output logic          busy,
  output logic          err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;

  state_t        state;
  logic          last;
  logic [TW-1:0] timer;

  logic [1:0]    pend;
  logic          winner;
  logic          win_write;
  logic [AW-1:0] win_waddr;
  logic [DW-1:0] win_wdata;
  logic [AW-1:0] win_raddr;
  logic          own_wreq;
  logic          own_rreq;
  logic          own_req;
  logic          slv_gnt;

  // Handshake: a master holds req until it sees a one-cycle gnt; that gnt is the
  // slave's gnt passed through combinationally while the owner still requests.
  always_comb begin
    pend      = m_wreq | m_rreq;
    winner    = pend[~last] ? ~last : last;
    win_write = m_wreq[winner];
    win_waddr = winner ? m_waddr[AW +: AW] : m_waddr[0 +: AW];
    win_wdata = winner ? m_wdata[DW +: DW] : m_wdata[0 +: DW];
    win_raddr = winner ? m_raddr[AW +: AW] : m_raddr[0 +: AW];
    own_wreq  = m_wreq[owner];
    own_rreq  = m_rreq[owner];
    own_req   = s_wreq ? own_wreq : own_rreq;
    slv_gnt   = s_wreq ? s_wgnt : s_rgnt;
    m_wgnt    = 2'b00;
    m_rgnt    = 2'b00;
    if (state == REQ && s_wreq && s_wgnt && own_wreq) m_wgnt[owner] = 1'b1;
    if (state == REQ && s_rreq && s_rgnt && own_rreq) m_rgnt[owner] = 1'b1;
  end

  assign m_rdata = s_rdata;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_wreq      <= 1'b0;
      s_rreq      <= 1'b0;
      s_waddr     <= '0;
      s_raddr     <= '0;
      s_wdata     <= '0;
      owner       <= 1'b0;
      last        <= 1'b1;
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|pend) begin
            owner <= winner;
            timer <= '0;
            state <= REQ;
            if (win_write) begin
              s_wreq  <= 1'b1;
              s_waddr <= win_waddr;
              s_wdata <= win_wdata;
            end else begin
              s_rreq  <= 1'b1;
              s_raddr <= win_raddr;
            end
          end
        end
        REQ: begin
          // Grant takes priority over both master abort and timeout.
          if (slv_gnt) begin
            s_wreq <= 1'b0;
            s_rreq <= 1'b0;
            last   <= owner;
            state  <= s_wreq ? IDLE : RDATA;
          end else if (!own_req) begin
            s_wreq <= 1'b0;
            s_rreq <= 1'b0;
            state  <= IDLE;
          end else if (timer == TIMER_LAST) begin
            s_wreq      <= 1'b0;
            s_rreq      <= 1'b0;
            err_timeout <= 1'b1;
            last        <= owner;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RDATA:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Bench for debug_bus_arbiter: random masters and slave, transaction-level reference
// model feeding cycle-stamped expectation queues, monitor comparing on every cycle.
module tb_debug_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int IW = 32 + 2 + AW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      m_wreq, m_wgnt, m_rreq, m_rgnt;
  logic [2*AW-1:0] m_waddr, m_raddr;
  logic [2*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            s_wreq, s_rreq, s_wgnt, s_rgnt;
  logic [AW-1:0]   s_waddr, s_raddr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic            owner, busy, err_timeout;

  // master channel state, index [master][0=write,1=read]
  logic            req_v   [2][2];
  logic [AW-1:0]   addr_v  [2][2];
  logic [DW-1:0]   data_v  [2][2];
  int              end_at  [2][2];
  int              next_at [2][2];
  logic            abort_v [2][2];
  logic [1:0]      dir_wreq;
  logic            dir_wgnt;
  logic            slv_wgnt, slv_rgnt;

  logic            drv_on = 1'b0;
  logic            model_on = 1'b0;
  logic            mon_on = 1'b0;
  int              cyc = 0;
  int              free_at = 0;
  int              m_last = 1;
  int              checks = 0;
  int              failures = 0;

  logic [IW-1:0]     iss_q[$];
  logic [35:0]       gnt_q[$];
  logic [31:0]       err_q[$];
  logic [32+DW-1:0]  rd_q[$];
  logic [32+DW:0]    slv_q[$];

  assign m_wreq  = {req_v[1][0], req_v[0][0]} | dir_wreq;
  assign m_rreq  = {req_v[1][1], req_v[0][1]};
  assign m_waddr = {addr_v[1][0], addr_v[0][0]};
  assign m_wdata = {data_v[1][0], data_v[0][0]};
  assign m_raddr = {addr_v[1][1], addr_v[0][1]};
  assign s_wgnt  = slv_wgnt | dir_wgnt;
  assign s_rgnt  = slv_rgnt;

  debug_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_wreq(m_wreq), .m_wgnt(m_wgnt), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_rreq(m_rreq), .m_rgnt(m_rgnt), .m_raddr(m_raddr), .m_rdata(m_rdata),
    .s_wreq(s_wreq), .s_rreq(s_rreq), .s_wgnt(s_wgnt), .s_rgnt(s_rgnt),
    .s_waddr(s_waddr), .s_raddr(s_raddr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .owner(owner), .busy(busy), .err_timeout(err_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit any_req();
    bit r = 0;
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < 2; ch++) r |= req_v[m][ch];
    return r;
  endfunction

  // Reference model: round-robin choice among pending masters, write before read,
  // then the fate of the transaction (grant after d cycles, abort, timeout) is drawn
  // here and all resulting events are scheduled by cycle arithmetic.
  task automatic arbitrate();
    logic [1:0]    pend;
    logic [DW-1:0] rd;
    logic [3:0]    pat;
    int w, ch, c, d, g, k, r;
    for (int m = 0; m < 2; m++) pend[m] = req_v[m][0] | req_v[m][1];
    if (pend == 2'b00) return;
    w  = pend[1 - m_last] ? 1 - m_last : m_last;
    ch = req_v[w][0] ? 0 : 1;
    c  = cyc;
    iss_q.push_back({32'(c + 1), 1'(w), 1'(ch), addr_v[w][ch], (ch == 0) ? data_v[w][0] : DW'(0)});
    r = $urandom_range(0, 19);
    if (r < 2) begin
      err_q.push_back(32'(c + 1 + TO));
      free_at = c + 1 + TO;
      m_last  = w;
    end else if (r < 4) begin
      k = $urandom_range(1, 3);
      end_at[w][ch]  = c + 1 + k;
      abort_v[w][ch] = 1'b1;
      free_at        = c + 2 + k;
    end else begin
      d   = (r == 19) ? TO - 1 : $urandom_range(0, 3);
      g   = c + 1 + d;
      rd  = $urandom;
      pat = 4'b0000;
      if (ch == 0) pat[2 + w] = 1'b1;
      else         pat[w] = 1'b1;
      gnt_q.push_back({32'(g), pat});
      slv_q.push_back({32'(g), 1'(ch), rd});
      if (ch == 1) rd_q.push_back({32'(g + 1), rd});
      end_at[w][ch]  = g + 1;
      abort_v[w][ch] = 1'b0;
      free_at        = g + 1 + ch;
      m_last         = w;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (model_on && cyc >= free_at) arbitrate();
      cyc++;
    end
  end

  // master drivers
  initial begin
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < 2; ch++) begin
        req_v[m][ch] = 1'b0; addr_v[m][ch] = '0; data_v[m][ch] = '0;
        end_at[m][ch] = -1; next_at[m][ch] = 0; abort_v[m][ch] = 1'b0;
      end
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++)
        for (int ch = 0; ch < 2; ch++) begin
          if (req_v[m][ch] && end_at[m][ch] == cyc) begin
            req_v[m][ch]   = 1'b0;
            next_at[m][ch] = cyc + (abort_v[m][ch] ? 1 : 0) + int'($urandom_range(0, 2));
          end
          if (drv_on && !req_v[m][ch] && cyc >= next_at[m][ch]) begin
            req_v[m][ch]  = 1'b1;
            addr_v[m][ch] = AW'($urandom_range(0, 1023)) << 2;
            data_v[m][ch] = $urandom;
          end
        end
    end
  end

  // slave responder following the model's plan
  initial begin
    logic [32+DW:0] e;
    logic [DW-1:0]  rd_val;
    int             rd_at;
    slv_wgnt = 1'b0; slv_rgnt = 1'b0; s_rdata = '0; rd_at = -1; rd_val = '0;
    forever begin
      @(posedge clk);
      #1;
      slv_wgnt = 1'b0;
      slv_rgnt = 1'b0;
      s_rdata  = $urandom;
      if (cyc == rd_at) s_rdata = rd_val;
      if (slv_q.size() > 0 && slv_q[0][32+DW -: 32] == 32'(cyc)) begin
        e = slv_q.pop_front();
        if (e[DW]) begin
          slv_rgnt = s_rreq;
          rd_at    = cyc + 1;
          rd_val   = e[DW-1:0];
        end else begin
          slv_wgnt = s_wreq;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [IW-1:0]    e;
    logic [35:0]      gr;
    logic [32+DW-1:0] rr;
    logic [3:0]       exp_g;
    logic             exp_e, new_iss, prev_sreq;
    prev_sreq = 1'b0;
    forever begin
      @(negedge clk);
      new_iss = (s_wreq | s_rreq) & ~prev_sreq;
      if (mon_on) begin
        if (iss_q.size() > 0 && iss_q[0][IW-1 -: 32] == 32'(cyc)) begin
          e = iss_q.pop_front();
          chk("issue",
              {new_iss, owner, s_wreq, s_rreq, e[AW+DW] ? s_raddr : s_waddr, e[AW+DW] ? DW'(0) : s_wdata},
              {1'b1, e[AW+DW+1], ~e[AW+DW], e[AW+DW], e[DW +: AW], e[DW-1:0]});
        end else begin
          chk("no_issue", new_iss, 1'b0);
        end
        exp_g = 4'b0000;
        if (gnt_q.size() > 0 && gnt_q[0][35:4] == 32'(cyc)) begin
          gr    = gnt_q.pop_front();
          exp_g = gr[3:0];
        end
        chk("grant", {m_wgnt, m_rgnt}, exp_g);
        exp_e = 1'b0;
        if (err_q.size() > 0 && err_q[0] == 32'(cyc)) begin
          void'(err_q.pop_front());
          exp_e = 1'b1;
        end
        chk("err_timeout", err_timeout, exp_e);
        if (rd_q.size() > 0 && rd_q[0][32+DW-1 -: 32] == 32'(cyc)) begin
          rr = rd_q.pop_front();
          chk("rdata", m_rdata, rr[DW-1:0]);
        end
        chk("busy", busy, cyc < free_at);
      end
      prev_sreq = s_wreq | s_rreq;
    end
  end

  // main sequence
  initial begin
    int n;
    rst = 1'b1; dir_wreq = 2'b00; dir_wgnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_wreq", s_wreq, 1'b0);
    chk("rst_s_rreq", s_rreq, 1'b0);
    chk("rst_s_addr", {s_waddr, s_raddr, s_wdata}, '0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_gnt", {m_wgnt, m_rgnt}, 4'b0000);
    drv_on = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; model_on = 1'b1; mon_on = 1'b1;

    repeat (3000) @(posedge clk);
    drv_on = 1'b0;
    n = 0;
    while ((any_req() || cyc < free_at) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_in_time", n < 2000, 1'b1);
    repeat (4) @(negedge clk);
    chk("iss_q_empty", iss_q.size(), 0);
    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    // reset in the middle of a write transaction
    mon_on = 1'b0; model_on = 1'b0;
    @(posedge clk);
    #1 dir_wreq = 2'b10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_s_wreq", s_wreq, 1'b1);
    chk("pre_rst_owner", owner, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; dir_wgnt = 1'b1;
    @(negedge clk);
    chk("post_rst_s_wreq", s_wreq, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_owner", owner, 1'b0);
    chk("post_rst_s_waddr", s_waddr, '0);
    chk("post_rst_wgnt", m_wgnt, 2'b00);
    chk("post_rst_err", err_timeout, 1'b0);
    @(posedge clk);
    #1;
    dir_wgnt = 1'b0; dir_wreq = 2'b00;
    @(negedge clk);
    chk("abort_wgnt", m_wgnt, 2'b00);
    repeat (2) @(negedge clk);
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_err", err_timeout, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
